// File: rtl/ram_dump_uart.sv
`default_nettype none
// ============================================================================
//  Module   : ram_dump_uart
//  Brief    : Reads a window of data RAM over a synchronous read port and
//             streams every word out of a UART 8N1 transmitter as uppercase
//             ASCII hex text, one space or CR LF after each word.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_dump_uart #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 12,
    parameter int DUMP_BASE      = 0,
    parameter int DUMP_WORDS     = 64,
    parameter int WORDS_PER_LINE = 8,
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD           = 115200
) (
    input  logic                  CLK_50,
    input  logic                  resetN,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_baud_raw = CLK_FREQ / BAUD;
    localparam int c_baud_div = (c_baud_raw < 2) ? 2 : c_baud_raw;
    localparam int c_baud_w   = $clog2(c_baud_div);
    localparam int c_ndig     = DATA_WIDTH / 4;
    localparam int c_char_w   = $clog2(c_ndig + 2);
    localparam int c_line_w   = $clog2(WORDS_PER_LINE + 1);

    localparam logic [c_baud_w-1:0]   c_baud_last = c_baud_w'(c_baud_div - 1);
    localparam logic [c_char_w-1:0]   c_sep_idx   = c_char_w'(c_ndig);
    localparam logic [c_char_w-1:0]   c_lf_idx    = c_char_w'(c_ndig + 1);
    localparam logic [c_line_w-1:0]   c_line_last = c_line_w'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_base      = ADDR_WIDTH'(DUMP_BASE);
    localparam logic [ADDR_WIDTH-1:0] c_last_word = ADDR_WIDTH'(DUMP_WORDS - 1);
    localparam logic [3:0]            c_stop_bit  = 4'd9;

    // FSM encoding. The "next char / next word / finish" decision has no
    // state of its own: it is taken on the closing edge of the stop bit.
    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_read = 2'd1;
    localparam logic [1:0] c_load = 2'd2;
    localparam logic [1:0] c_send = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]            r_state;
    logic                  r_start_d;
    logic                  r_read_cnt;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [ADDR_WIDTH-1:0] r_word_idx;
    logic [c_line_w-1:0]   r_line_cnt;
    logic [c_char_w-1:0]   r_char_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic [9:0]            r_shift;
    logic [3:0]            r_bit_cnt;
    logic [c_baud_w-1:0]   r_baud_cnt;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_start_edge;
    logic                  w_last_word;
    logic                  w_crlf;
    logic                  w_last_char;
    logic                  w_bit_end;
    logic [c_char_w-1:0]   w_char_next;
    logic [c_char_w-1:0]   w_load_idx;
    logic [7:0]            w_load_byte;

    // ASCII code of character 'idx' of the current word's text sequence
    function automatic logic [7:0] char_of(input logic [DATA_WIDTH-1:0] word,
                                           input logic [c_char_w-1:0]   idx,
                                           input logic                  crlf);
        logic [3:0] v_nib;
        logic [7:0] v_ch;
        v_nib = 4'h0;
        for (int i = 0; i < c_ndig; i++) begin
            if (idx == c_char_w'(i)) v_nib = word[DATA_WIDTH-1-4*i -: 4];
        end
        if (idx < c_sep_idx) begin
            v_ch = (v_nib < 4'd10) ? (8'h30 + {4'h0, v_nib}) : (8'h37 + {4'h0, v_nib});
        end else if (idx == c_sep_idx) begin
            v_ch = crlf ? 8'h0D : 8'h20;
        end else begin
            v_ch = 8'h0A;
        end
        return v_ch;
    endfunction

    assign w_start_edge = start & ~r_start_d;
    assign w_last_word  = (r_word_idx == c_last_word);
    assign w_crlf       = (r_line_cnt == c_line_last) || w_last_word;
    assign w_last_char  = w_crlf ? (r_char_idx == c_lf_idx) : (r_char_idx == c_sep_idx);
    assign w_bit_end    = (r_baud_cnt == c_baud_last);
    assign w_char_next  = r_char_idx + c_char_w'(1);
    // LOAD starts a word at its current char; back-to-back frames use the next one
    assign w_load_idx   = (r_state == c_load) ? r_char_idx : w_char_next;
    assign w_load_byte  = char_of(r_word, w_load_idx, w_crlf);

    assign mem_addr = r_mem_addr;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign done     = r_done;

    // Dump sequencer, RAM addressing and UART shifter
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            r_state    <= c_idle;
            r_start_d  <= 1'b0;
            r_read_cnt <= 1'b0;
            r_mem_addr <= c_base;
            r_word_idx <= '0;
            r_line_cnt <= '0;
            r_char_idx <= '0;
            r_word     <= '0;
            r_shift    <= '1;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_start_d <= start;
            case (r_state)
                c_idle: begin
                    if (w_start_edge) begin
                        r_mem_addr <= c_base;
                        r_word_idx <= '0;
                        r_line_cnt <= '0;
                        r_char_idx <= '0;
                        r_read_cnt <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_state    <= c_read;
                    end
                end
                c_read: begin
                    // address issued on entry; data valid on the 2nd closing edge
                    if (!r_read_cnt) begin
                        r_read_cnt <= 1'b1;
                    end else begin
                        r_read_cnt <= 1'b0;
                        r_word     <= mem_rdata;
                        r_char_idx <= '0;
                        r_state    <= c_load;
                    end
                end
                c_load: begin
                    r_shift    <= {1'b1, w_load_byte, 1'b0};
                    r_tx       <= 1'b0;
                    r_bit_cnt  <= '0;
                    r_baud_cnt <= '0;
                    r_state    <= c_send;
                end
                c_send: begin
                    if (!w_bit_end) begin
                        r_baud_cnt <= r_baud_cnt + c_baud_w'(1);
                    end else begin
                        r_baud_cnt <= '0;
                        if (r_bit_cnt != c_stop_bit) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_shift   <= {1'b0, r_shift[9:1]};
                            r_tx      <= r_shift[1];
                        end else if (!w_last_char) begin
                            // next char of the same word follows with no idle gap
                            r_char_idx <= w_char_next;
                            r_shift    <= {1'b1, w_load_byte, 1'b0};
                            r_tx       <= 1'b0;
                            r_bit_cnt  <= '0;
                        end else if (w_last_word) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_idle;
                        end else begin
                            r_word_idx <= r_word_idx + ADDR_WIDTH'(1);
                            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
                            r_line_cnt <= (r_line_cnt == c_line_last) ? '0
                                                                      : r_line_cnt + c_line_w'(1);
                            r_read_cnt <= 1'b0;
                            r_state    <= c_read;
                        end
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_dump_uart.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_dump_uart
//  Brief    : Scoreboard bench for ram_dump_uart. Stimulus fills a RAM model
//             with random words and pushes the expected text bytes; a UART
//             receiver process decodes tx and compares each frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dump_uart;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int BASE  = 15;
    localparam int WORDS = 3;
    localparam int WPL   = 2;
    localparam int DIV   = 10;   // 1000 Hz / 100 baud

    logic          clk;
    logic          resetN;
    logic          start;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          tx;
    logic          busy;
    logic          done;

    logic [DW-1:0] ram [16];

    typedef struct {
        logic [7:0]    data;
        int            gap;    // idle cycles before the start bit, -1 = unchecked
        logic [AW-1:0] addr;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    ram_dump_uart #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DUMP_BASE(BASE), .DUMP_WORDS(WORDS),
        .WORDS_PER_LINE(WPL), .CLK_FREQ(1000), .BAUD(100)
    ) dut (
        .CLK_50(clk), .resetN(resetN), .start(start), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .tx(tx), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous-read RAM model
    initial begin
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hex_char(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
    endfunction

    function automatic void push(input logic [7:0] d, input int gap, input int addr);
        exp_t e;
        e.data = d;
        e.gap  = gap;
        e.addr = AW'(addr);
        exp_q.push_back(e);
    endfunction

    // expected text of one whole dump; returns number of bytes
    function automatic int model_dump();
        int n = 0;
        for (int w = 0; w < WORDS; w++) begin
            int a = (BASE + w) % 16;
            int v = int'(ram[a]);
            for (int d = 0; d < DW / 4; d++) begin
                int nib = (v >> (DW - 4 - 4 * d)) & 15;
                push(hex_char(nib), (d != 0) ? 0 : ((w == 0) ? -1 : 3), a);
                n++;
            end
            if (((w + 1) % WPL == 0) || (w == WORDS - 1)) begin
                push(8'h0D, 0, a);
                push(8'h0A, 0, a);
                n += 2;
            end else begin
                push(8'h20, 0, a);
                n++;
            end
        end
        return n;
    endfunction

    // UART receiver / scoreboard monitor, samples on falling edges
    initial begin
        bit         m_active = 0;
        int         m_cnt    = 0;
        int         m_idle   = 0;
        int         m_gap    = 0;
        logic [9:0] m_bits   = '0;
        logic [AW-1:0] m_addr = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                m_active = 0;
                m_idle   = 0;
            end else if (!m_active) begin
                if (tx === 1'b0) begin
                    m_active = 1;
                    m_cnt    = 0;
                    m_gap    = m_idle;
                    m_addr   = mem_addr;
                end else begin
                    m_idle++;
                end
            end else begin
                m_cnt++;
                if (m_cnt % DIV == 4) m_bits[m_cnt / DIV] = tx;
                if (m_cnt == 10 * DIV - 1) begin
                    m_bits[0] = 1'b0;
                    m_active  = 0;
                    m_idle    = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame: got byte %0h expected none", m_bits[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", m_bits[8:1], e.data);
                        check("stop_bit", m_bits[9], 1);
                        check("frame_addr", m_addr, e.addr);
                        if (e.gap >= 0) check("frame_gap", m_gap, e.gap);
                    end
                end
            end
        end
    end

    // mode 0: one-cycle pulse, 1: start held high, 2: pulse then a second edge mid-dump
    task automatic run_dump(input int mode);
        int nbytes;
        int cyc;
        int want;
        start = 1'b0;
        repeat (2) @(negedge clk);
        nbytes = model_dump();
        want   = 3 + nbytes * DIV * 10 + 3 * (WORDS - 1);
        start  = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_edge", busy, 1);
        check("done_after_edge", done, 0);
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1 && mode != 1) start = 1'b0;
            if (cyc == 2) check("tx_idle_before_start_bit", tx, 1);
            if (cyc == 3) check("first_start_bit", tx, 0);
            if (mode == 2 && cyc == 500) start = 1'b1;
        end
        check("done_cycle", cyc, want);
        check("busy_at_done", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        repeat (30) @(posedge clk);
        #1;
        check("no_retrigger_busy", busy, 0);
        check("done_holds", done, 1);
        start = 1'b0;
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 16; i++) ram[i] = DW'($urandom);
    endtask

    initial begin
        int nbytes;
        int cyc;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        resetN = 1'b0;
        start  = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_addr", mem_addr, BASE);
        @(negedge clk);
        resetN = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("idle_tx", tx, 1);

        // directed word with letters and digits, then random contents
        fill_ram();
        ram[15] = 16'hA3F0;
        run_dump(0);
        run_dump(0);          // new edge after done: same RAM, same bytes
        fill_ram();
        run_dump(1);
        fill_ram();
        run_dump(2);

        // reset during data bit 4 of the second char
        fill_ram();
        start = 1'b0;
        repeat (2) @(negedge clk);
        nbytes = model_dump();
        start  = 1'b1;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < 155) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        check("busy_before_reset", busy, 1);
        resetN = 1'b0;
        exp_q.delete();
        #1;
        check("midframe_reset_tx", tx, 1);
        check("midframe_reset_busy", busy, 0);
        check("midframe_reset_addr", mem_addr, BASE);
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        run_dump(0);

        for (int k = 0; k < 3; k++) begin
            fill_ram();
            run_dump(0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
